// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: supported opcodes, the decoded-instruction record
// and the all-zero bubble that is issued when nothing valid leaves decode.
package decode_stage_pkg;

  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [6:0]  opcode;
  } dec_t;

  localparam dec_t BUBBLE = '0;

  function automatic logic signed [31:0] sext_imm12(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 reads 0.
// With DECODE_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] REG_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);

  logic [31:0] r_regs [0:31];

  // Writes to x0 are dropped by the address check; x0 storage stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs[0] <= '0;
      for (int i = 1; i < 32; i++) r_regs[i] <= REG_INIT;
    end else if (i_wr_addr != 5'd0) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rs1_data = '0;
    o_rs2_data = '0;
    if (i_rs1_addr != 5'd0) begin
      o_rs1_data = r_regs[i_rs1_addr];
`ifdef DECODE_BYPASS_EN
      if (i_rs1_addr == i_wr_addr) o_rs1_data = i_wr_data;
`endif
    end
    if (i_rs2_addr != 5'd0) begin
      o_rs2_data = r_regs[i_rs2_addr];
`ifdef DECODE_BYPASS_EN
      if (i_rs2_addr == i_wr_addr) o_rs2_data = i_wr_data;
`endif
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, register read, hazard stall and bubble issue.
// Optional macro DECODE_BYPASS_EN forwards writeback data and removes the writeback stall.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] REG_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] pc,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [4:0]  rd_number,
  output logic [31:0] immediate,
  output logic [6:0]  func7,
  output logic [2:0]  func3,
  output logic [6:0]  opcode
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_func3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_func7;
  logic        w_rs2_used;
  logic        w_supported;
  logic        w_hazard_ex;
  logic        w_hazard_wb;
  logic        w_accept;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  dec_t        w_dec_p0;
  dec_t        r_dec_p1;

  assign w_opcode    = instr[6:0];
  assign w_rd        = instr[11:7];
  assign w_func3     = instr[14:12];
  assign w_rs1       = instr[19:15];
  assign w_rs2       = instr[24:20];
  assign w_func7     = instr[31:25];
  assign w_rs2_used  = (w_opcode == OP_ALU);
  assign w_supported = (w_opcode == OP_ALU) || (w_opcode == OP_ALUI);

  decode_stage_regfile #(
    .REG_INIT (REG_INIT)
  ) regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  // rd_number is the instruction now in execute; its result is not yet written.
  assign w_hazard_ex = (rd_number != 5'd0) &&
                       ((rd_number == w_rs1) || (w_rs2_used && (rd_number == w_rs2)));

`ifdef DECODE_BYPASS_EN
  assign w_hazard_wb = 1'b0;
`else
  assign w_hazard_wb = (wb_rd != 5'd0) &&
                       ((wb_rd == w_rs1) || (w_rs2_used && (wb_rd == w_rs2)));
`endif

  assign instr_ready = !reset && !(w_hazard_ex || w_hazard_wb);
  assign w_accept    = instr_valid && instr_ready;

  // Stage p0: decode and register read in the acceptance cycle
  always_comb begin
    w_dec_p0 = BUBBLE;
    if (w_accept && w_supported) begin
      w_dec_p0.pc      = instr_pc;
      w_dec_p0.rs1_val = w_rs1_data;
      w_dec_p0.rs2_val = w_rs2_data;
      w_dec_p0.rd      = w_rd;
      w_dec_p0.imm     = (w_opcode == OP_ALUI) ? sext_imm12(instr[31:20]) : 32'h0;
      w_dec_p0.func7   = w_func7;
      w_dec_p0.func3   = w_func3;
      w_dec_p0.opcode  = w_opcode;
    end
  end

  // Stage p1: registered hand-off to execute
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_p1 <= BUBBLE;
    end else begin
      r_dec_p1 <= w_dec_p0;
    end
  end

  assign pc        = r_dec_p1.pc;
  assign rs1_val   = r_dec_p1.rs1_val;
  assign rs2_val   = r_dec_p1.rs2_val;
  assign rd_number = r_dec_p1.rd;
  assign immediate = r_dec_p1.imm;
  assign func7     = r_dec_p1.func7;
  assign func3     = r_dec_p1.func3;
  assign opcode    = r_dec_p1.opcode;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a small execute-stage model closing the
// writeback loop and a scoreboard of expected decode outputs per cycle.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam logic [31:0] TB_REG_INIT = 32'h0000_0011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_number;
  logic [31:0] immediate;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic [6:0]  opcode;

  int          n_tests = 0;
  int          n_fail  = 0;
  dec_t        exp_q[$];
  logic [31:0] m_regs [32];
  bit          exec_en;
  dec_t        obs;

  always #5 clk = ~clk;

  decode_stage #(
    .REG_INIT (TB_REG_INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .pc          (pc),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rd_number   (rd_number),
    .immediate   (immediate),
    .func7       (func7),
    .func3       (func3),
    .opcode      (opcode)
  );

  assign obs = {pc, rs1_val, rs2_val, rd_number, immediate, func7, func3, opcode};

  task automatic check(input string tag, input logic [149:0] act, input logic [149:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef DECODE_BYPASS_EN
    if (a == wb_rd) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic dec_t m_decode(input logic [31:0] ins, input logic [31:0] p);
    dec_t d;
    d = '0;
    if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) begin
      d.pc      = p;
      d.rs1_val = m_read(ins[19:15]);
      d.rs2_val = m_read(ins[24:20]);
      d.rd      = ins[11:7];
      d.imm     = (ins[6:0] == 7'b0010011) ? {{20{ins[31]}}, ins[31:20]} : 32'h0;
      d.func7   = ins[31:25];
      d.func3   = ins[14:12];
      d.opcode  = ins[6:0];
    end
    return d;
  endfunction

  // One clock: register model update and execute-stage model (add / add-immediate)
  task automatic tick;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        was_rst;
    logic [4:0]  pre_wb_rd;
    logic [31:0] pre_wb_data;
    ex_rd       = rd_number;
    ex_res      = (opcode == 7'b0110011) ? rs1_val + rs2_val : rs1_val + immediate;
    was_rst     = reset;
    pre_wb_rd   = wb_rd;
    pre_wb_data = wb_data;
    @(posedge clk);
    if (was_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 32'h0 : TB_REG_INIT;
    end else if (pre_wb_rd != 5'd0) begin
      m_regs[pre_wb_rd] = pre_wb_data;
    end
    #1;
    if (was_rst) begin
      wb_rd   = 5'd0;
      wb_data = 32'h0;
    end else if (exec_en) begin
      wb_rd   = ex_rd;
      wb_data = ex_res;
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] p,
                      input bit v, input bit exp_rdy);
    dec_t e;
    instr       = ins;
    instr_pc    = p;
    instr_valid = v;
    #1;
    check({tag, ".ready"}, 150'(instr_ready), 150'(exp_rdy));
    e = (v && exp_rdy && !reset) ? m_decode(ins, p) : BUBBLE;
    exp_q.push_back(e);
    tick;
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 150'(1), 150'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, ".out"}, obs, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; instr = '0; instr_pc = '0; instr_valid = 1'b0;
    wb_rd = '0; wb_data = '0; exec_en = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    step("rst0", 32'h0, 32'h0, 1'b0, 1'b0);
    step("rst1", 32'h0050_0093, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;

    step("addi5", 32'h0050_0093, 32'h100, 1'b1, 1'b1);
    check("addi5.opcode", 150'(opcode), 150'(7'b0010011));
    check("addi5.rd", 150'(rd_number), 150'(5'd1));
    check("addi5.rs1", 150'(rs1_val), 150'(32'h0));
    check("addi5.imm", 150'(immediate), 150'(32'h5));
    check("addi5.rs2_init", 150'(rs2_val), 150'(TB_REG_INIT));

    step("addim1", 32'hFFF0_0113, 32'h104, 1'b1, 1'b1);
    check("addim1.imm", 150'(immediate), 150'(32'hFFFF_FFFF));

    step("idle_a", 32'h0, 32'h0, 1'b0, 1'b1);
    step("idle_b", 32'h0, 32'h0, 1'b0, 1'b1);
    step("idle_c", 32'h0, 32'h0, 1'b0, 1'b1);
    exec_en = 1'b0; wb_rd = 5'd2; wb_data = 32'h7;
    step("pre_x2", 32'h0, 32'h0, 1'b0, 1'b1);
    wb_rd = 5'd0; wb_data = 32'h0; exec_en = 1'b1;

    step("add", 32'h0020_81B3, 32'h108, 1'b1, 1'b1);
    check("add.rs1", 150'(rs1_val), 150'(32'h5));
    check("add.rs2", 150'(rs2_val), 150'(32'h7));
    check("add.imm", 150'(immediate), 150'(32'h0));

    step("addi9", 32'h0090_0093, 32'h10C, 1'b1, 1'b1);
    step("dep_stall1", 32'h0010_81B3, 32'h110, 1'b1, 1'b0);
    check("dep_stall1.opcode", 150'(opcode), 150'(7'd0));
    check("dep_stall1.rd", 150'(rd_number), 150'(5'd0));
`ifndef DECODE_BYPASS_EN
    step("dep_stall2", 32'h0010_81B3, 32'h110, 1'b1, 1'b0);
`endif
    step("dep_issue", 32'h0010_81B3, 32'h110, 1'b1, 1'b1);
    check("dep_issue.rs1", 150'(rs1_val), 150'(32'h9));
    check("dep_issue.rs2", 150'(rs2_val), 150'(32'h9));

    exec_en = 1'b0; wb_rd = 5'd0; wb_data = 32'hDEAD;
    step("x0_rd", 32'h0010_0293, 32'h114, 1'b1, 1'b1);
    check("x0_rd.rs1", 150'(rs1_val), 150'(32'h0));
    step("x0_add", 32'h0000_0333, 32'h118, 1'b1, 1'b1);
    check("x0_add.rs2", 150'(rs2_val), 150'(32'h0));
    wb_data = 32'h0; exec_en = 1'b1;

    step("unsup", 32'h0000_2383, 32'h11C, 1'b1, 1'b1);
    check("unsup.opcode", 150'(opcode), 150'(7'd0));
    step("idle_d", 32'h0, 32'h0, 1'b0, 1'b1);

    step("addi3", 32'h0030_0093, 32'h120, 1'b1, 1'b1);
    step("stall_r", 32'h0010_81B3, 32'h124, 1'b1, 1'b0);
    reset = 1'b1;
    step("rst_mid", 32'h0010_81B3, 32'h124, 1'b1, 1'b0);
    reset = 1'b0;
    step("post_rst0", 32'h0, 32'h0, 1'b0, 1'b1);
    check("post_rst0.pc", 150'(pc), 150'(32'h0));
    step("post_rst1", 32'h0, 32'h0, 1'b0, 1'b1);

    step("rd_x1_init", 32'h0010_81B3, 32'h200, 1'b1, 1'b1);
    check("rd_x1_init.rs1", 150'(rs1_val), 150'(TB_REG_INIT));

    step("addi_rs2f", 32'h0030_0213, 32'h204, 1'b1, 1'b1);
    step("rs2_haz", 32'h0040_02B3, 32'h208, 1'b1, 1'b0);
`ifndef DECODE_BYPASS_EN
    step("rs2_haz2", 32'h0040_02B3, 32'h208, 1'b1, 1'b0);
`endif
    step("rs2_issue", 32'h0040_02B3, 32'h208, 1'b1, 1'b1);
    check("rs2_issue.rs2", 150'(rs2_val), 150'(32'h3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
